// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: latches operands and an opcode mask, walks the enabled opcodes through an
// external combinational ALU and streams each (opcode, result) pair over valid/ready.
module alu_op_sequencer #(
    parameter int DW = 4,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic [7:0]    op_mask,
    output logic          busy,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_s,
    input  logic [RW-1:0] alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [2:0]    res_op,
    output logic [RW-1:0] res_data,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]    alu_s_q, alu_s_d, res_op_q, res_op_d;
    logic [7:0]    rem_q, rem_d;
    logic          res_valid_q, res_valid_d;
    logic [RW-1:0] res_data_q, res_data_d;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
    endfunction

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        rem_d       = rem_q;
        res_valid_d = res_valid_q;
        res_op_d    = res_op_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: if (start) begin
                alu_a_d = op_a;
                alu_b_d = op_b;
                rem_d   = op_mask;
                alu_s_d = (op_mask == 8'd0) ? alu_s_q : lowest(op_mask);
                state_d = (op_mask == 8'd0) ? DONE : ISSUE;
            end
            ISSUE: begin
                res_data_d  = alu_y;
                res_op_d    = alu_s_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: if (res_ready) begin
                // retire the accepted opcode before choosing the next one
                res_valid_d = 1'b0;
                rem_d       = rem_q & ~(8'd1 << res_op_q);
                alu_s_d     = (rem_d == 8'd0) ? alu_s_q : lowest(rem_d);
                state_d     = (rem_d == 8'd0) ? DONE : ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rem_q       <= '0;
            res_valid_q <= 1'b0;
            res_op_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            rem_q       <= rem_d;
            res_valid_q <= res_valid_d;
            res_op_q    <= res_op_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign res_valid = res_valid_q;
    assign res_op    = res_op_q;
    assign res_data  = res_data_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives alu_op_sequencer against the team ALU and a queue-based
// reference model, comparing all outputs every cycle plus directed literal checks.
module tb_alu_op_sequencer;
    logic       clk, rst, start, busy, res_valid, res_ready, done;
    logic [3:0] op_a, op_b, alu_a, alu_b;
    logic [7:0] op_mask, alu_y, res_data;
    logic [2:0] alu_s, res_op;

    int n_tests, n_fail, n_done, n_got, cyc, t_start, t_valid, t_done, mode, sc;
    logic [2:0] got_op[1024];
    logic [7:0] got_data[1024];
    int sweep[8] = '{8, 2, 1, 7, 10, 11, 15, 2};

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        logic [7:0] xa, xb;
        logic [3:0] na, ia;
        xa = {4'd0, a};
        xb = {4'd0, b};
        na = 4'd0 - a;
        ia = ~a;
        case (s)
            3'd0: alu_f = xa + xb;
            3'd1: alu_f = xa - xb;
            3'd2: alu_f = xa & xb;
            3'd3: alu_f = xa | xb;
            3'd4: alu_f = {4'd0, ia};
            3'd5: alu_f = {4'd0, na};
            3'd6: alu_f = xa * xb;
            default: alu_f = xa >> 1;
        endcase
    endfunction

    assign alu_y = alu_f(alu_a, alu_b, alu_s);

    alu_op_sequencer #(.DW(4), .RW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_mask(op_mask),
        .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op), .res_data(res_data),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the sequence is a queue of expected (opcode, result) pairs
    logic [10:0] q[$];
    logic       synced = 1'b0, pend = 1'b0, fv_pend = 1'b0;
    logic       e_busy = 0, e_done = 0, e_valid = 0;
    logic [2:0] e_op = 0, e_s = 0;
    logic [7:0] e_data = 0;
    logic [3:0] e_a = 0, e_b = 0;

    always @(negedge clk) begin
        cyc++;
        if (synced) begin
            n_tests++;
            if ({busy, done, res_valid, res_op, res_data, alu_a, alu_b, alu_s} !==
                {e_busy, e_done, e_valid, e_op, e_data, e_a, e_b, e_s}) begin
                n_fail++;
                $display("FAIL cycle %0d outputs busy/done/valid/op/data/a/b/s: got %b %b %b %0d %h %h %h %0d expected %b %b %b %0d %h %h %h %0d",
                         cyc, busy, done, res_valid, res_op, res_data, alu_a, alu_b, alu_s,
                         e_busy, e_done, e_valid, e_op, e_data, e_a, e_b, e_s);
            end
            if (res_valid && res_ready && n_got < 1024) begin
                got_op[n_got] = res_op;
                got_data[n_got] = res_data;
                n_got++;
            end
            if (res_valid && fv_pend) begin
                t_valid = cyc;
                fv_pend = 1'b0;
            end
            if (done) begin
                n_done++;
                t_done = cyc;
            end
        end
        if (rst) begin
            synced = 1; pend = 0; e_busy = 0; e_done = 0; e_valid = 0;
            e_op = 0; e_s = 0; e_data = 0; e_a = 0; e_b = 0;
            q.delete();
        end else if (synced) begin
            if (e_done) begin
                e_done = 0;
                e_busy = 0;
            end else if (!e_busy) begin
                if (start) begin
                    t_start = cyc;
                    fv_pend = 1'b1;
                    e_a = op_a;
                    e_b = op_b;
                    e_busy = 1;
                    for (int k = 0; k < 8; k++)
                        if (op_mask[k]) q.push_back({3'(k), alu_f(op_a, op_b, 3'(k))});
                    if (q.size() == 0) e_done = 1;
                    else begin
                        e_s = q[0][10:8];
                        pend = 1;
                    end
                end
            end else if (pend) begin
                pend = 0;
                e_valid = 1;
                {e_op, e_data} = q[0];
            end else if (e_valid && res_ready) begin
                void'(q.pop_front());
                e_valid = 0;
                if (q.size() == 0) e_done = 1;
                else begin
                    e_s = q[0][10:8];
                    pend = 1;
                end
            end
        end
    end

    // res_ready: 0 tied high, 1 random, 2 held low for 5 cycles on every result
    initial begin
        res_ready = 1'b1;
        sc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) res_ready = 1'b1;
            else if (mode == 1) res_ready = $urandom_range(0, 3) != 0;
            else if (!res_valid) begin
                sc = 0;
                res_ready = 1'b0;
            end else begin
                res_ready = sc >= 5;
                sc++;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic kick(input logic [3:0] a, input logic [3:0] b, input logic [7:0] m);
        for (int i = 0; i < 100 && busy; i++) @(posedge clk);
        @(posedge clk);
        #1;
        start = 1; op_a = a; op_b = b; op_mask = m;
        @(posedge clk);
        #1;
        start = 0; op_a = 4'($urandom); op_b = 4'($urandom); op_mask = 8'($urandom);
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] m);
        int d0;
        d0 = n_done;
        kick(a, b, m);
        for (int i = 0; i < 400 && n_done == d0; i++) @(negedge clk);
        chk("seq_timeout", n_done - d0, 1);
    endtask

    initial begin
        int b0, d0;
        logic [7:0] m;
        rst = 1; start = 0; op_a = 0; op_b = 0; op_mask = 0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_alu_s", alu_s, 0);

        b0 = n_got;
        run(4'd5, 4'd3, 8'h01);
        chk("t1_count", n_got - b0, 1);
        chk("t1_op", got_op[b0], 0);
        chk("t1_data", got_data[b0], 8);
        chk("t1_valid_lat", t_valid - t_start, 2);
        chk("t1_done_lat", t_done - t_start, 3);

        b0 = n_got;
        run(4'd5, 4'd3, 8'hFF);
        chk("t2_count", n_got - b0, 8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_op", got_op[b0 + k], k);
            chk("t2_data", got_data[b0 + k], sweep[k]);
        end
        chk("t2_done_lat", t_done - t_start, 17);

        mode = 2;
        b0 = n_got;
        run(4'd5, 4'd3, 8'h42);
        chk("t3_count", n_got - b0, 2);
        chk("t3_op0", got_op[b0], 1);
        chk("t3_data0", got_data[b0], 2);
        chk("t3_op1", got_op[b0 + 1], 6);
        chk("t3_data1", got_data[b0 + 1], 15);

        mode = 0;
        b0 = n_got;
        run(4'd5, 4'd3, 8'h00);
        chk("t4_count", n_got - b0, 0);
        chk("t4_done_lat", t_done - t_start, 1);

        mode = 2;
        d0 = n_done;
        kick(4'd5, 4'd3, 8'hFF);
        for (int i = 0; i < 20 && !res_valid; i++) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("t5_valid_cleared", res_valid, 0);
        chk("t5_busy_cleared", busy, 0);
        repeat (5) @(negedge clk);
        chk("t5_no_done", n_done - d0, 0);
        mode = 0;
        b0 = n_got;
        run(4'd9, 4'd4, 8'hFF);
        chk("t5_rerun_count", n_got - b0, 8);
        chk("t5_rerun_mul", got_data[b0 + 6], 36);

        b0 = n_got;
        d0 = n_done;
        kick(4'd5, 4'd3, 8'h06);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                start = 0;
                break;
            end
            start = 1; op_mask = 8'h80; op_a = 4'd15; op_b = 4'd15;
        end
        start = 0;
        repeat (4) @(negedge clk);
        chk("t6_done", n_done - d0, 1);
        chk("t6_count", n_got - b0, 2);
        chk("t6_op0", got_op[b0], 1);
        chk("t6_op1", got_op[b0 + 1], 2);
        chk("t6_data1", got_data[b0 + 1], 1);

        mode = 1;
        for (int r = 0; r < 40; r++) begin
            m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            b0 = n_got;
            run(4'($urandom), 4'($urandom), m);
            chk("rnd_count", n_got - b0, $countones(m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
